uart_rx_module: RTL and testbench

- Serial UART receiver that sits on the far end of the team's UART transmit line and consumes its serial output.
- Converts an 8N1 asynchronous bit stream on rx into parallel bytes, presented with a one-cycle data_valid strobe.
- Detects false start bits and framing errors.
- Sits between the board-level serial pin and the byte-consuming logic (command decoder / FIFO).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_module.sv | 156 +++++++++++++++
 tb/tb_uart_rx_module.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and line levels.
// Used by both the RX and TX sides of the serial link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both stages reset to the idle line level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver with mid-bit sampling, false-start rejection and framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_error output.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_error_q, parity_error_d;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    idx_d           = idx_q;
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d       = par_bad_q;
    parity_error_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s == START_LVL) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high level here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          if (rx_s == START_LVL) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          par_bad_d = (rx_s != ^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid stop bit so an immediately following start edge is not missed.
        if (cnt_q == BIT_LAST) begin
          state_d = IDLE;
          if (rx_s == STOP_LVL) begin
            data_out_d     = shift_q;
            data_valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_error_d = par_bad_q;
`endif
          end else begin
            framing_error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q       <= par_bad_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  // The assembly register carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parity_error_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: vector table of single frames plus hand-written corner sequences.
module tb_uart_rx_module;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT_NOM = 2 + CPB / 2 + (DB + 1) * CPB + (PAR ? CPB : 0);
  localparam int BRK     = 2 * (LAT_NOM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          framing_error;
  logic          parity_error;
  logic          busy;

  uart_rx_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       nv = 0;
  int       nf = 0;
  int       np = 0;
  logic [7:0] vdata [0:255];
  int       vcyc  [0:255];

  always @(negedge clk) begin
    if (data_valid) begin
      vdata[nv & 255] <= data_out;
      vcyc[nv & 255]  <= cyc;
      nv              <= nv + 1;
    end
    if (framing_error) nf <= nf + 1;
    if (parity_error)  np <= np + 1;
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR) send_bit((^d) ^ pflip);
    send_bit(stop);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       pflip;
    int         ev;
    int         ef;
    int         ep;
    logic [7:0] edata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int bv, bf, bp, t0, lat;

    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF});
    vecs.push_back('{8'h55, 1'b0, 1'b0, 0, 1, 0, 8'hFF});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1, 0, 0, 8'h80});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1, 0, 0, 8'h01});
    if (PAR) vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 1, 8'h07});

    // Reset and long idle
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;
    idle(500);
    check("idle_data", data_out, 0);
    check("idle_valid_cnt", nv, 0);
    check("idle_ferr_cnt", nf, 0);
    check("idle_perr_cnt", np, 0);
    check("idle_busy", busy, 0);

    // 0xA5 with latency measurement
    bv = nv; bf = nf; t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(CPB);
    check("a5_valid_cnt", nv - bv, 1);
    check("a5_data", data_out, 8'hA5);
    check("a5_ferr_cnt", nf - bf, 0);
    lat = vcyc[bv & 255] - t0;
    check("a5_latency_in_window", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 2), 1);

    foreach (vecs[i]) begin
      bv = nv; bf = nf; bp = np;
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].pflip);
      idle(CPB);
      check($sformatf("vec%0d_valid_cnt", i), nv - bv, vecs[i].ev);
      check($sformatf("vec%0d_ferr_cnt", i), nf - bf, vecs[i].ef);
      check($sformatf("vec%0d_perr_cnt", i), np - bp, vecs[i].ep);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].edata);
    end

    // Back-to-back frames, no idle gap
    bv = nv; bf = nf;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(CPB);
    check("b2b_valid_cnt", nv - bv, 2);
    check("b2b_first", vdata[bv & 255], 8'h3C);
    check("b2b_second", vdata[(bv + 1) & 255], 8'hFF);
    check("b2b_ferr_cnt", nf - bf, 0);

    // Short low glitch
    bv = nv; bf = nf;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_during", busy, 1);
    repeat (15) @(negedge clk);
    check("glitch_busy_after", busy, 0);
    check("glitch_valid_cnt", nv - bv, 0);
    check("glitch_ferr_cnt", nf - bf, 0);

    // Line held low: two pseudo-frames end in framing errors, then release
    bv = nv; bf = nf;
    rx = 1'b0;
    repeat (BRK) @(negedge clk);
    idle(40);
    check("break_ferr_cnt", nf - bf, 2);
    check("break_valid_cnt", nv - bv, 0);
    check("break_data_held", data_out, 8'hFF);
    check("break_busy_after", busy, 0);

    // Reset in the middle of 0x81, then 0x42
    bv = nv; bf = nf;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_data", data_out, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(30);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(CPB);
    check("midrst_valid_cnt", nv - bv, 1);
    check("midrst_data_after", data_out, 8'h42);
    check("midrst_ferr_cnt", nf - bf, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
